// File: rtl/cancid_ctx_mgr.sv
// Per-stream matcher context manager: restores/saves engine state per stream and counts matched packets.
// Optional per-stream match count table enabled by macro CANCID_PER_STREAM_CNT_EN.
module cancid_ctx_mgr #(
    parameter int SID_W   = 6,
    parameter int STATE_W = 11,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_state,
    input  logic [SID_W-1:0]   stream_id,
    input  logic               new_stream_id,
    input  logic               enable,
    input  logic               eop,
    input  logic [STATE_W-1:0] eng_state_out,
    input  logic               eng_accept_out,
    output logic [STATE_W-1:0] eng_state_in,
    output logic               eng_state_in_vld,
    output logic               fired,
    output logic [CNT_W-1:0]   count,
    input  logic [SID_W-1:0]   rd_sid,
    output logic [CNT_W-1:0]   rd_cnt,
    output logic               proto_err
);

    localparam int NSTREAMS = 2 ** SID_W;
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
        if (inc && (c != CNT_MAX)) begin
            return c + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            return c;
        end
    endfunction

    logic                 state_r;
    logic                 state_nx_s;
    logic [SID_W-1:0]     sid_q_r;
    logic                 en_q_r;
    logic [STATE_W-1:0]   eng_state_in_r;
    logic                 eng_state_in_vld_r;
    logic                 fired_r;
    logic [CNT_W-1:0]     count_r;
    logic                 proto_err_r;
    logic [STATE_W-1:0]   ctx_mem_r [NSTREAMS];

    logic                 eop_ok_s;
    logic                 load_ok_s;
    logic                 proto_bad_s;
    logic                 commit_s;
    logic                 hit_s;
    logic                 bypass_s;
    logic [STATE_W-1:0]   restore_s;

    // Event qualification, next state and restore-value selection
    always_comb begin
        eop_ok_s    = (state_r == ST_RUN) && eop;
        load_ok_s   = load_state && ((state_r == ST_IDLE) || eop);
        proto_bad_s = (load_state && (state_r == ST_RUN) && !eop) ||
                      (eop && (state_r == ST_IDLE));
        commit_s    = eop_ok_s && en_q_r;
        hit_s       = fired_r || eng_accept_out;
        // The context being saved this cycle is not yet in ctx_mem, so forward it.
        bypass_s    = commit_s && (stream_id == sid_q_r);
        if (new_stream_id) begin
            restore_s = {STATE_W{1'b0}};
        end else if (bypass_s) begin
            restore_s = eng_state_out;
        end else begin
            restore_s = ctx_mem_r[stream_id];
        end
        case (state_r)
            ST_IDLE: begin
                if (load_ok_s) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (eop && !load_state) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Control registers, engine load strobe, match flag and global count
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r            <= ST_IDLE;
            sid_q_r            <= {SID_W{1'b0}};
            en_q_r             <= 1'b0;
            eng_state_in_r     <= {STATE_W{1'b0}};
            eng_state_in_vld_r <= 1'b0;
            fired_r            <= 1'b0;
            count_r            <= {CNT_W{1'b0}};
            proto_err_r        <= 1'b0;
        end else begin
            state_r            <= state_nx_s;
            eng_state_in_vld_r <= load_ok_s;
            if (load_ok_s) begin
                sid_q_r        <= stream_id;
                en_q_r         <= enable;
                eng_state_in_r <= restore_s;
            end
            if (load_ok_s) begin
                fired_r <= 1'b0;
            end else if (eop_ok_s && !en_q_r) begin
                fired_r <= 1'b0;
            end else if ((state_r == ST_RUN) && eng_accept_out) begin
                fired_r <= 1'b1;
            end
            if (commit_s) begin
                count_r <= sat_inc(count_r, hit_s);
            end
            if (proto_bad_s) begin
                proto_err_r <= 1'b1;
            end
        end
    end

    // Context store; deliberately not reset, new streams start from state 0 instead
    always_ff @(posedge clk) begin
        if (!rst && commit_s) begin
            ctx_mem_r[sid_q_r] <= eng_state_out;
        end
    end

`ifdef CANCID_PER_STREAM_CNT_EN
    logic [CNT_W-1:0] tbl_r [NSTREAMS];
    logic [CNT_W-1:0] rd_cnt_r;

    // Per-stream saturating counts; read port samples before this cycle's update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSTREAMS; i++) begin
                tbl_r[i] <= {CNT_W{1'b0}};
            end
            rd_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (commit_s) begin
                tbl_r[sid_q_r] <= sat_inc(tbl_r[sid_q_r], hit_s);
            end
            if (load_ok_s && new_stream_id) begin
                tbl_r[stream_id] <= {CNT_W{1'b0}};
            end
            rd_cnt_r <= tbl_r[rd_sid];
        end
    end

    assign rd_cnt = rd_cnt_r;
`else
    logic unused_rd_sid_s;
    assign unused_rd_sid_s = ^rd_sid;
    assign rd_cnt          = {CNT_W{1'b0}};
`endif

    assign eng_state_in     = eng_state_in_r;
    assign eng_state_in_vld = eng_state_in_vld_r;
    assign fired            = fired_r;
    assign count            = count_r;
    assign proto_err        = proto_err_r;

endmodule

// File: tb/tb_cancid_ctx_mgr.sv
// Directed self-checking bench for cancid_ctx_mgr (CNT_W=4 so saturation is reachable).
module tb_cancid_ctx_mgr;
    localparam int SID_W = 6;
    localparam int STATE_W = 11;
    localparam int CNT_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               load_state;
    logic [SID_W-1:0]   stream_id;
    logic               new_stream_id;
    logic               enable;
    logic               eop;
    logic [STATE_W-1:0] eng_state_out;
    logic               eng_accept_out;
    logic [STATE_W-1:0] eng_state_in;
    logic               eng_state_in_vld;
    logic               fired;
    logic [CNT_W-1:0]   count;
    logic [SID_W-1:0]   rd_sid;
    logic [CNT_W-1:0]   rd_cnt;
    logic               proto_err;

    int n_cmp = 0;
    int n_err = 0;

    cancid_ctx_mgr #(.SID_W(SID_W), .STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .load_state(load_state), .stream_id(stream_id),
        .new_stream_id(new_stream_id), .enable(enable), .eop(eop),
        .eng_state_out(eng_state_out), .eng_accept_out(eng_accept_out),
        .eng_state_in(eng_state_in), .eng_state_in_vld(eng_state_in_vld),
        .fired(fired), .count(count), .rd_sid(rd_sid), .rd_cnt(rd_cnt),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [SID_W-1:0] sid, input logic nw, input logic en);
        load_state = 1'b1; stream_id = sid; new_stream_id = nw; enable = en;
    endtask

    task automatic idle_in();
        load_state = 1'b0; new_stream_id = 1'b0; enable = 1'b0;
        eop = 1'b0; eng_accept_out = 1'b0;
    endtask

    logic [CNT_W-1:0] exp_rd;

    initial begin
        rst = 1'b1; idle_in(); stream_id = '0; rd_sid = '0; eng_state_out = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_fired", fired, 0);
        chk("rst_vld", eng_state_in_vld, 0);
        chk("rst_state_in", eng_state_in, 0);
        chk("rst_proto", proto_err, 0);
        chk("rst_rdcnt", rd_cnt, 0);

        // New stream 3, one accept, eop saves 0x1A3
        load(6'd3, 1'b1, 1'b1); eng_state_out = 11'h055;
        step();
        chk("new3_vld", eng_state_in_vld, 1);
        chk("new3_state_in", eng_state_in, 0);
        chk("new3_fired_clr", fired, 0);
        idle_in(); eng_state_out = 11'h101; eng_accept_out = 1'b1;
        step();
        chk("new3_vld_pulse", eng_state_in_vld, 0);
        chk("new3_fired", fired, 1);
        idle_in(); eng_state_out = 11'h1A3; eop = 1'b1;
        step();
        chk("new3_count", count, 1);
        chk("new3_fired_eop", fired, 1);
        idle_in();
        step();
        chk("new3_hold_state_in", eng_state_in, 0);

        // Reload stream 3: restored state, no match
        load(6'd3, 1'b0, 1'b1);
        step();
        chk("re3_state_in", eng_state_in, 11'h1A3);
        chk("re3_fired", fired, 0);
        idle_in(); eng_state_out = 11'h0C7;
        step();
        eop = 1'b1;
        step();
        chk("re3_count", count, 1);
        chk("re3_fired", fired, 0);
        idle_in();

        // Back-to-back same stream 5: bypass of the state being saved
        load(6'd5, 1'b1, 1'b1);
        step();
        idle_in(); eng_state_out = 11'h2B4; eop = 1'b1; load(6'd5, 1'b0, 1'b1);
        step();
        chk("b2b_vld", eng_state_in_vld, 1);
        chk("b2b_bypass", eng_state_in, 11'h2B4);
        chk("b2b_count", count, 1);
        // Accept only on eop; FSM must still be RUN, so no protocol error
        idle_in(); eop = 1'b1; eng_accept_out = 1'b1; eng_state_out = 11'h011;
        step();
        chk("eopacc_count", count, 2);
        chk("b2b_run_proto", proto_err, 0);
        idle_in();
        step();

        // Disabled stream 7: accepts counted nowhere
        load(6'd7, 1'b1, 1'b0);
        step();
        idle_in(); eng_accept_out = 1'b1;
        step();
        chk("dis_fired_run", fired, 1);
        eop = 1'b1;
        step();
        chk("dis_count", count, 2);
        chk("dis_fired_eop", fired, 0);
        idle_in();
        step();

        // eop while IDLE
        eop = 1'b1; eng_accept_out = 1'b1;
        step();
        idle_in();
        chk("idle_eop_proto", proto_err, 1);
        chk("idle_eop_count", count, 2);
        step();
        chk("proto_sticky", proto_err, 1);

        // 17 matched packets on stream 9 saturate at 15
        for (int i = 0; i < 17; i++) begin
            load(6'd9, (i == 0) ? 1'b1 : 1'b0, 1'b1);
            step();
            idle_in(); eop = 1'b1; eng_accept_out = 1'b1; eng_state_out = 11'h3C0;
            step();
            idle_in();
        end
        chk("sat_count", count, 15);
        rd_sid = 6'd9;
        step();
`ifdef CANCID_PER_STREAM_CNT_EN
        exp_rd = 4'd15;
`else
        exp_rd = 4'd0;
`endif
        chk("sat_rdcnt", rd_cnt, exp_rd);

        // Reset mid-packet with eop/accept asserted: everything cleared, no save
        load(6'd9, 1'b0, 1'b1);
        step();
        idle_in(); eng_accept_out = 1'b1;
        step();
        rst = 1'b1; eop = 1'b1; eng_state_out = 11'h7FF;
        step();
        rst = 1'b0; idle_in();
        chk("mid_rst_count", count, 0);
        chk("mid_rst_fired", fired, 0);
        chk("mid_rst_proto", proto_err, 0);
        chk("mid_rst_vld", eng_state_in_vld, 0);
        chk("mid_rst_state_in", eng_state_in, 0);
        chk("mid_rst_rdcnt", rd_cnt, 0);
        load(6'd9, 1'b0, 1'b1);
        step();
        chk("mid_rst_no_save", eng_state_in, 11'h3C0);
        idle_in(); eop = 1'b1;
        step();
        chk("post_rst_count", count, 0);
        idle_in();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cancid_ctx_mgr.md
CANCID_CTX_MGR -- requirements
Module: cancid_ctx_mgr

Interface
REQ-001 SHALL have parameter SID_W, default 6: stream-ID width; NSTREAMS = 2**SID_W.
REQ-002 SHALL have parameter STATE_W, default 11: matcher state width.
REQ-003 SHALL have parameter CNT_W, default 16: match counter width.
REQ-004 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port load_state  in  1  packet start; restore context for stream_id.
REQ-007 SHALL have port stream_id  in  SID_W  stream of the packet being loaded.
REQ-008 SHALL have port new_stream_id  in  1  with load_state: stream unseen, start from state 0.
REQ-009 SHALL have port enable  in  1  with load_state: matcher enabled for this stream.
REQ-010 SHALL have port eop  in  1  packet end; finalise count, save context.
REQ-011 SHALL have port eng_state_out  in  STATE_W  current engine state.
REQ-012 SHALL have port eng_accept_out  in  1  engine match pulse.
REQ-013 SHALL have port eng_state_in  out  STATE_W  state to load into engine.
REQ-014 SHALL have port eng_state_in_vld  out  1  one-cycle engine load strobe.
REQ-015 SHALL have port fired  out  1  sticky match flag for current packet.
REQ-016 SHALL have port count  out  CNT_W  global matched-packet count.
REQ-017 SHALL have port rd_sid  in  SID_W  per-stream count read address.
REQ-018 SHALL have port rd_cnt  out  CNT_W  per-stream count read data.
REQ-019 SHALL have port proto_err  out  1  sticky protocol-error flag.

Function
REQ-020 SHALL implement FSM IDLE/RUN; IDLE->RUN on load_state; RUN->IDLE on eop without load_state; RUN->RUN on eop with load_state (back-to-back).
REQ-021 SHALL, on load_state sampled at cycle T, register sid_q, en_q, and drive eng_state_in_vld=1 for exactly cycle T+1.
REQ-022 SHALL select eng_state_in at T+1: 0 if new_stream_id; else eng_state_out if eop, en_q, and stream_id==sid_q at T (save-restore bypass); else ctx_mem[stream_id].
REQ-023 SHALL clear fired at T+1, then set fired on any eng_accept_out sampled in RUN; eng_accept_out ignored in IDLE.
REQ-024 SHALL, on eop in RUN at cycle E with en_q=1, write ctx_mem[sid_q]<=eng_state_out and add (fired OR eng_accept_out at E) to count, visible E+1.
REQ-025 SHALL, on eop with en_q=0, skip ctx write and count update, and clear fired at E+1.
REQ-026 SHALL saturate count (and per-stream counts) at 2**CNT_W-1; no wrap.
REQ-027 SHALL flag proto_err, sticky, on load_state in RUN without eop, or eop in IDLE; offending event otherwise ignored.
REQ-028 SHALL hold eng_state_in stable outside load cycles; eng_state_in_vld=0 otherwise.

Reset
REQ-029 SHALL on rst: FSM IDLE; fired=0; count=0; eng_state_in=0; eng_state_in_vld=0; proto_err=0; rd_cnt=0; per-stream counts=0.
REQ-030 SHALL NOT reset ctx_mem; streams after reset are loaded with new_stream_id=1.
REQ-031 SHALL abandon an in-flight packet on rst: no ctx write, no count update.

Configuration
REQ-032 SHALL honour macro CANCID_PER_STREAM_CNT_EN.
REQ-033 SHALL with macro defined: keep NSTREAMS x CNT_W count table; increment entry sid_q alongside count (REQ-024); clear entry stream_id on load_state with new_stream_id; rd_cnt <= table[rd_sid] registered, one-cycle latency, read-before-write on collision.
REQ-034 SHALL with macro undefined: omit the table; rd_cnt constant 0; rd_sid ignored.

Verification
REQ-035 SHALL cover: load sid=3 new=1 en=1, one accept, eop -> eng_state_in=0 at T+1, fired=1, count=1, ctx_mem[3]=last state_out.
REQ-036 SHALL cover: reload sid=3 new=0 -> eng_state_in equals saved state; no accept, eop -> count unchanged, fired=0.
REQ-037 SHALL cover: eop with load_state same cycle, same sid=5, en=1 -> eng_state_in = eng_state_out of eop cycle (bypass), FSM stays RUN.
REQ-038 SHALL cover: accept only in eop cycle -> count increments; en=0 packet with accepts -> count unchanged, fired=0 after eop.
REQ-039 SHALL cover: CNT_W=4, 17 matched packets -> count=15; with CANCID_PER_STREAM_CNT_EN, rd_sid=sid -> rd_cnt=15 next cycle.
REQ-040 SHALL cover: eop in IDLE -> proto_err=1 until rst, count unchanged; rst mid-packet -> all REQ-029 values next cycle.
